ram_6ab_sequencer: RTL and testbench

//  Initiator for a single-port sync RAM port (address/data/wren in, q out; q registered, 1-cycle read latency,

---
 rtl/ram_6ab_sequencer.sv | 136 +++++++++++++
 tb/tb_ram_6ab_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_6ab_sequencer.sv
// Single-port sync RAM initiator: arbitrates a CPU req/ack channel, a burst
// SCAN read engine and a whole-RAM CLEAR engine onto one registered RAM port.
module ram_6ab_sequencer #(
  parameter int addr_width_g = 11,
  parameter int data_width_g = 8
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    cpu_req,
  input  logic                    cpu_wr,
  input  logic [addr_width_g-1:0] cpu_addr,
  input  logic [data_width_g-1:0] cpu_wdata,
  output logic                    cpu_ack,
  output logic [data_width_g-1:0] cpu_rdata,
  input  logic                    scan_start,
  input  logic [addr_width_g-1:0] scan_base,
  input  logic [addr_width_g:0]   scan_len,
  output logic                    scan_valid,
  output logic [data_width_g-1:0] scan_data,
  output logic [addr_width_g-1:0] scan_addr,
  input  logic                    clr_start,
  input  logic [data_width_g-1:0] clr_value,
  output logic                    busy,
  output logic                    done,
  output logic [addr_width_g-1:0] ram_address,
  output logic [data_width_g-1:0] ram_data,
  output logic                    ram_wren,
  input  logic [data_width_g-1:0] ram_q
);
  localparam int A = addr_width_g;
  localparam int D = data_width_g;
  localparam logic [A:0] DEPTH = {1'b1, {A{1'b0}}};
  localparam logic [A:0] ONE   = {{A{1'b0}}, 1'b1};

  typedef enum logic [2:0] {S_IDLE, S_CPU_ACC, S_CPU_DONE, S_SCAN, S_CLEAR} state_t;

  state_t         state_q;
  logic [A:0]     cnt_q;
  logic [A-1:0]   ram_address_q, scan_addr_q;
  logic [D-1:0]   ram_data_q, cpu_rdata_q;
  logic           ram_wren_q, cpu_ack_q, scan_valid_q, busy_q, done_q;
  logic [A:0]     scan_len_c;

  assign scan_len_c = (scan_len > DEPTH) ? DEPTH : scan_len;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      ram_address_q <= '0;
      ram_data_q    <= '0;
      ram_wren_q    <= 1'b0;
      cpu_rdata_q   <= '0;
      cpu_ack_q     <= 1'b0;
      scan_addr_q   <= '0;
      scan_valid_q  <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      cpu_ack_q    <= 1'b0;
      done_q       <= 1'b0;
      scan_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // busy_q still high here means the scan drain beat; starts are dropped
          // but a CPU access may begin since its RAM cycle lands after the beat.
          if (clr_start && !busy_q) begin
            state_q       <= S_CLEAR;
            ram_address_q <= '0;
            ram_data_q    <= clr_value;
            ram_wren_q    <= 1'b1;
            cnt_q         <= DEPTH - ONE;
            busy_q        <= 1'b1;
          end else if (scan_start && !busy_q && scan_len != '0) begin
            state_q       <= S_SCAN;
            ram_address_q <= scan_base;
            ram_wren_q    <= 1'b0;
            cnt_q         <= scan_len_c - ONE;
            busy_q        <= 1'b1;
          end else begin
            busy_q <= 1'b0;
            if (cpu_req && !cpu_ack_q) begin
              state_q       <= S_CPU_ACC;
              ram_address_q <= cpu_addr;
              ram_data_q    <= cpu_wdata;
              ram_wren_q    <= cpu_wr;
            end
          end
        end
        S_CPU_ACC: begin
          ram_wren_q <= 1'b0;
          state_q    <= S_CPU_DONE;
        end
        S_CPU_DONE: begin
          cpu_rdata_q <= ram_q;
          cpu_ack_q   <= 1'b1;
          state_q     <= S_IDLE;
        end
        S_SCAN: begin
          scan_valid_q <= 1'b1;
          scan_addr_q  <= ram_address_q;
          if (cnt_q == '0) begin
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            ram_address_q <= ram_address_q + A'(1);
            cnt_q         <= cnt_q - ONE;
          end
        end
        S_CLEAR: begin
          if (cnt_q == '0) begin
            ram_wren_q <= 1'b0;
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= S_IDLE;
          end else begin
            ram_address_q <= ram_address_q + A'(1);
            cnt_q         <= cnt_q - ONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cpu_ack     = cpu_ack_q;
  assign cpu_rdata   = cpu_rdata_q;
  assign scan_valid  = scan_valid_q;
  assign scan_data   = ram_q;
  assign scan_addr   = scan_addr_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign ram_address = ram_address_q;
  assign ram_data    = ram_data_q;
  assign ram_wren    = ram_wren_q;
endmodule

// File: tb/tb_ram_6ab_sequencer.sv
// Bench for ram_6ab_sequencer: behavioural write-first RAM, CPU vector table,
// scoreboard queues for CPU results and scan beats, hand-written engine sequences.
module tb_ram_6ab_sequencer;
  localparam int A = 4;
  localparam int D = 8;
  localparam int N = 16;

  logic clock = 1'b0, reset_n = 1'b0;
  logic cpu_req = 0, cpu_wr = 0, cpu_ack;
  logic [A-1:0] cpu_addr = '0, scan_base = '0, scan_addr, ram_address;
  logic [D-1:0] cpu_wdata = '0, cpu_rdata, scan_data, clr_value = '0, ram_data, ram_q;
  logic [A:0] scan_len = '0;
  logic scan_start = 0, scan_valid, clr_start = 0, busy, done, ram_wren;

  ram_6ab_sequencer #(.addr_width_g(A), .data_width_g(D)) dut (
    .clock(clock), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .scan_start(scan_start), .scan_base(scan_base), .scan_len(scan_len),
    .scan_valid(scan_valid), .scan_data(scan_data), .scan_addr(scan_addr),
    .clr_start(clr_start), .clr_value(clr_value), .busy(busy), .done(done),
    .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q)
  );

  always #5 clock = ~clock;

  // write-first registered RAM; do_preload loads mem[i]=i+0x10 while the DUT is idle
  logic [D-1:0] mem [N];
  logic do_preload = 1'b0;
  always @(posedge clock) begin
    if (do_preload) begin
      for (int i = 0; i < N; i++) mem[i] <= 8'(i + 16);
    end else if (ram_wren) begin
      mem[ram_address] <= ram_data;
      ram_q <= ram_data;
    end else begin
      ram_q <= mem[ram_address];
    end
  end

  typedef struct {
    logic       wr;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } cpu_vec_t;

  logic [D-1:0]   shadow [N];
  logic [D-1:0]   cpu_sb [$];
  logic [A+D-1:0] scan_sb [$];
  int n_cmp = 0, n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic preload();
    do_preload = 1'b1;
    @(posedge clock); #1;
    do_preload = 1'b0;
    for (int i = 0; i < N; i++) shadow[i] = 8'(i + 16);
  endtask

  task automatic cpu_access(input cpu_vec_t v);
    int ack_cyc = 0, acks = 0, wrens = 0;
    logic [D-1:0] e;
    cpu_sb.push_back(v.exp);
    cpu_req = 1; cpu_wr = v.wr; cpu_addr = v.addr; cpu_wdata = v.wdata;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clock); #1;
      if (ram_wren) wrens++;
      if (cpu_ack) begin
        acks++;
        if (ack_cyc == 0) begin
          ack_cyc = c;
          cpu_req = 0;
          e = cpu_sb.pop_front();
          chk("cpu_rdata", cpu_rdata, e);
        end
      end
    end
    chk("cpu_ack_cycle", ack_cyc, 3);
    chk("cpu_ack_pulses", acks, 1);
    chk("cpu_wren_cycles", wrens, v.wr ? 1 : 0);
    if (v.wr) shadow[v.addr] = v.wdata;
  endtask

  task automatic scan(input int base, input int len);
    int eff;
    logic [A+D-1:0] e;
    eff = (len > N) ? N : len;
    for (int i = 0; i < eff; i++) scan_sb.push_back({4'((base + i) % N), shadow[(base + i) % N]});
    scan_start = 1; scan_base = 4'(base); scan_len = 5'(len);
    for (int c = 1; c <= eff + 3; c++) begin
      @(posedge clock); #1;
      if (c == 1) scan_start = 0;
      chk("scan_valid", scan_valid, (c >= 2 && c <= eff + 1) ? 1 : 0);
      chk("scan_done", done, (eff > 0 && c == eff + 1) ? 1 : 0);
      chk("scan_busy", busy, (eff > 0 && c <= eff + 1) ? 1 : 0);
      chk("scan_wren", ram_wren, 0);
      if (scan_valid) begin
        if (scan_sb.size() == 0) chk("scan_extra_beat", 1, 0);
        else begin
          e = scan_sb.pop_front();
          chk("scan_addr", scan_addr, e[A+D-1:D]);
          chk("scan_data", scan_data, e[D-1:0]);
        end
      end
    end
    chk("scan_missing_beats", scan_sb.size(), 0);
    scan_sb.delete();
  endtask

  initial begin
    cpu_vec_t vecs [5];
    int done_cyc, ack_cyc;
    vecs[0] = '{wr: 1'b0, addr: 4'd5, wdata: 8'h00, exp: 8'h15};
    vecs[1] = '{wr: 1'b1, addr: 4'd9, wdata: 8'hA5, exp: 8'hA5};
    vecs[2] = '{wr: 1'b0, addr: 4'd9, wdata: 8'h00, exp: 8'hA5};
    vecs[3] = '{wr: 1'b1, addr: 4'd0, wdata: 8'h42, exp: 8'h42};
    vecs[4] = '{wr: 1'b0, addr: 4'd0, wdata: 8'h00, exp: 8'h42};

    #2;
    chk("rst_ram_wren", ram_wren, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cpu_ack", cpu_ack, 0);
    chk("rst_scan_valid", scan_valid, 0);
    chk("rst_ram_address", ram_address, 0);
    @(posedge clock); #1;
    reset_n = 1;
    preload();

    foreach (vecs[i]) cpu_access(vecs[i]);

    scan(14, 4);
    scan(0, 0);
    scan(3, 20);

    // clear and scan requested together: clear wins, scan is dropped
    clr_start = 1; clr_value = 8'h3C; scan_start = 1; scan_base = 4'd2; scan_len = 5'd3;
    for (int c = 1; c <= 19; c++) begin
      @(posedge clock); #1;
      if (c == 1) begin clr_start = 0; scan_start = 0; end
      chk("clr_wren", ram_wren, (c <= N) ? 1 : 0);
      chk("clr_busy", busy, (c <= N) ? 1 : 0);
      chk("clr_done", done, (c == N + 1) ? 1 : 0);
      chk("clr_scan_valid", scan_valid, 0);
      if (c <= N) begin
        chk("clr_addr", ram_address, c - 1);
        chk("clr_data", ram_data, 8'h3C);
      end
    end
    for (int i = 0; i < N; i++) shadow[i] = 8'h3C;
    scan(0, 16);

    // CPU request raised mid-clear stalls until the clear completes
    done_cyc = 0; ack_cyc = 0;
    clr_start = 1; clr_value = 8'h5A;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clock); #1;
      if (c == 1) clr_start = 0;
      if (c == 3) begin
        cpu_req = 1; cpu_wr = 0; cpu_addr = 4'd2;
        cpu_sb.push_back(8'h5A);
      end
      if (done && done_cyc == 0) done_cyc = c;
      if (cpu_ack && ack_cyc == 0) begin
        ack_cyc = c;
        cpu_req = 0;
        if (cpu_sb.size() != 0) chk("stall_rdata", cpu_rdata, cpu_sb.pop_front());
      end
    end
    chk("stall_done_cycle", done_cyc, 17);
    chk("stall_ack_cycle", ack_cyc, 20);
    cpu_req = 0;
    for (int i = 0; i < N; i++) shadow[i] = 8'h5A;

    // reset asserted after 6 clear writes aborts the engine immediately
    preload();
    clr_start = 1; clr_value = 8'hEE;
    for (int c = 1; c <= 7; c++) begin
      @(posedge clock); #1;
      if (c == 1) clr_start = 0;
    end
    reset_n = 0;
    #1;
    chk("abort_wren", ram_wren, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    for (int i = 0; i < 6; i++) shadow[i] = 8'hEE;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset_n = 1;
    @(posedge clock); #1;
    chk("post_rst_busy", busy, 0);
    chk("post_rst_done", done, 0);
    scan(0, 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
